// File: rtl/cache_pkg.sv
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared types and load-extend / store-merge helpers for the cache.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

   localparam int OFFSET_W = 2;

   typedef enum logic [2:0] {
      MC_B  = 3'b000,
      MC_H  = 3'b001,
      MC_W  = 3'b010,
      MC_BU = 3'b100,
      MC_HU = 3'b101
   } memctl_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   // Unknown width codes fall through to a plain word access.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  mc);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (mc)
         MC_B:    res = {{24{b[7]}}, b};
         MC_BU:   res = {24'd0, b};
         MC_H:    res = {{16{h[15]}}, h};
         MC_HU:   res = {16'd0, h};
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  mc);
      logic [31:0] res;
      res = old;
      case (mc)
         MC_B: res[{off, 3'b000} +: 8] = wdata[7:0];
         MC_H: begin
            if (off[1]) res[31:16] = wdata[15:0];
            else        res[15:0]  = wdata[15:0];
         end
         default: res = wdata;
      endcase
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cache_lru.sv
// ============================================================================
// Module   : cache_lru
// Brief    : Per-set LRU age array with victim selection and age update.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cache_lru
   import cache_pkg::*;
#(
   parameter int WAYS = 2,
   parameter int SETS = 8,
   localparam int IDX_W = $clog2(SETS),
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] lookup_set,
   input  logic [WAYS-1:0]  lookup_valid,
   output logic [WAY_W-1:0] victim_way,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_set,
   input  logic [WAY_W-1:0] upd_way
);

   if (WAYS > 1) begin : g_lru_ages
      logic [WAY_W-1:0] age_q [SETS][WAYS];
      logic [WAY_W-1:0] age_d [SETS][WAYS];
      logic [WAY_W-1:0] old_age;
      logic             found_inv;

      always_comb begin
         age_d   = age_q;
         old_age = age_q[upd_set][upd_way];
         if (upd_en) begin
            for (int w = 0; w < WAYS; w++) begin
               if (WAY_W'(w) == upd_way)
                  age_d[upd_set][w] = '0;
               else if (age_q[upd_set][w] < old_age)
                  age_d[upd_set][w] = age_q[upd_set][w] + WAY_W'(1);
            end
         end
      end

      // Ages form a permutation, so exactly one way holds WAYS-1.
      always_comb begin
         victim_way = '0;
         found_inv  = 1'b0;
         for (int w = 0; w < WAYS; w++) begin
            if (!found_inv && !lookup_valid[w]) begin
               victim_way = WAY_W'(w);
               found_inv  = 1'b1;
            end
         end
         if (!found_inv) begin
            for (int w = 0; w < WAYS; w++) begin
               if (age_q[lookup_set][w] == WAY_W'(WAYS - 1))
                  victim_way = WAY_W'(w);
            end
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int s = 0; s < SETS; s++)
               for (int w = 0; w < WAYS; w++)
                  age_q[s][w] <= WAY_W'(w);
         end else begin
            age_q <= age_d;
         end
      end
   end else begin : g_lru_none
      logic unused_lru;
      assign victim_way = '0;
      assign unused_lru = ^{clk, rst, lookup_set, lookup_valid, upd_en, upd_set, upd_way};
   end

endmodule

`default_nettype wire

// File: rtl/cache_nway_ctrl.sv
// ============================================================================
// Module   : cache_nway_ctrl
// Brief    : N-way set-associative write-through data cache controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cache_nway_ctrl
   import cache_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int WAYS          = 2,
   parameter int SETS          = 8,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0]    cpu_wdata,
   input  logic [2:0]               memcontrol,
   input  logic                     cpu_flush,
   output logic                     cpu_busy,
   output logic                     cpu_ready,
   output logic [DATA_WIDTH-1:0]    cpu_rdata,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic [2:0]               mem_memcontrol,
   input  logic                     mem_ack,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic [CNT_WIDTH-1:0]     hit_count,
   output logic [CNT_WIDTH-1:0]     miss_count
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDRESS_WIDTH - OFFSET_W - IDX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   state_e                   state_q, state_d;
   logic                     ready_q, ready_d;
   logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
   logic                     mem_req_q, mem_req_d;
   logic                     mem_we_q, mem_we_d;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
   logic [2:0]               mem_mc_q, mem_mc_d;
   logic [CNT_WIDTH-1:0]     hit_cnt_q, hit_cnt_d;
   logic [CNT_WIDTH-1:0]     miss_cnt_q, miss_cnt_d;
   logic [ADDRESS_WIDTH-1:0] req_addr_q, req_addr_d;
   logic [2:0]               req_mc_q, req_mc_d;
   logic                     req_hit_q, req_hit_d;
   logic [WAY_W-1:0]         req_way_q, req_way_d;

   logic [WAYS-1:0]          valid_q [SETS];
   logic [WAYS-1:0]          valid_d [SETS];
   logic [TAG_W-1:0]         tag_q   [SETS][WAYS];
   logic [TAG_W-1:0]         tag_d   [SETS][WAYS];
   logic [DATA_WIDTH-1:0]    data_q  [SETS][WAYS];
   logic [DATA_WIDTH-1:0]    data_d  [SETS][WAYS];

   logic [IDX_W-1:0]         lk_set, rq_set;
   logic [TAG_W-1:0]         lk_tag, rq_tag;
   logic                     lk_hit;
   logic [WAY_W-1:0]         lk_way;
   logic [WAY_W-1:0]         lru_victim;
   logic                     lru_upd_en;
   logic [IDX_W-1:0]         lru_upd_set;
   logic [WAY_W-1:0]         lru_upd_way;

   assign lk_set = cpu_addr[OFFSET_W +: IDX_W];
   assign lk_tag = cpu_addr[ADDRESS_WIDTH-1 -: TAG_W];
   assign rq_set = req_addr_q[OFFSET_W +: IDX_W];
   assign rq_tag = req_addr_q[ADDRESS_WIDTH-1 -: TAG_W];

   always_comb begin
      lk_hit = 1'b0;
      lk_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
            lk_hit = 1'b1;
            lk_way = WAY_W'(w);
         end
      end
   end

   cache_lru #(
      .WAYS (WAYS),
      .SETS (SETS)
   ) u_lru (
      .clk          (clk),
      .rst          (rst),
      .lookup_set   (rq_set),
      .lookup_valid (valid_q[rq_set]),
      .victim_way   (lru_victim),
      .upd_en       (lru_upd_en),
      .upd_set      (lru_upd_set),
      .upd_way      (lru_upd_way)
   );

   always_comb begin
      state_d     = state_q;
      ready_d     = 1'b0;
      rdata_d     = '0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_mc_d    = mem_mc_q;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      req_addr_d  = req_addr_q;
      req_mc_d    = req_mc_q;
      req_hit_d   = req_hit_q;
      req_way_d   = req_way_q;
      valid_d     = valid_q;
      tag_d       = tag_q;
      data_d      = data_q;
      lru_upd_en  = 1'b0;
      lru_upd_set = lk_set;
      lru_upd_way = lk_way;

      case (state_q)
         ST_IDLE: begin
            if (cpu_flush) begin
               for (int s = 0; s < SETS; s++)
                  valid_d[s] = '0;
            end else if (cpu_req) begin
               if (lk_hit) begin
                  if (~&hit_cnt_q) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
               end else begin
                  if (~&miss_cnt_q) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
               end
               req_addr_d = cpu_addr;
               req_mc_d   = memcontrol;
               req_hit_d  = lk_hit;
               req_way_d  = lk_way;
               mem_mc_d   = memcontrol;
               if (cpu_we) begin
                  state_d     = ST_WRITE;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = cpu_addr;
                  mem_wdata_d = cpu_wdata;
               end else if (lk_hit) begin
                  ready_d    = 1'b1;
                  rdata_d    = load_extend(data_q[lk_set][lk_way], cpu_addr[1:0], memcontrol);
                  lru_upd_en = 1'b1;
               end else begin
                  state_d    = ST_FILL;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = {cpu_addr[ADDRESS_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
               end
            end
         end

         ST_FILL: begin
            if (mem_ack) begin
               valid_d[rq_set][lru_victim] = 1'b1;
               tag_d[rq_set][lru_victim]   = rq_tag;
               data_d[rq_set][lru_victim]  = mem_rdata;
               lru_upd_en  = 1'b1;
               lru_upd_set = rq_set;
               lru_upd_way = lru_victim;
               mem_req_d   = 1'b0;
               ready_d     = 1'b1;
               rdata_d     = load_extend(mem_rdata, req_addr_q[1:0], req_mc_q);
               state_d     = ST_IDLE;
            end
         end

         ST_WRITE: begin
            if (mem_ack) begin
               // Store misses do not allocate; only a hit touches the array.
               if (req_hit_q) begin
                  data_d[rq_set][req_way_q] = store_merge(data_q[rq_set][req_way_q],
                                                          mem_wdata_q, req_addr_q[1:0], req_mc_q);
                  lru_upd_en  = 1'b1;
                  lru_upd_set = rq_set;
                  lru_upd_way = req_way_q;
               end
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               ready_d   = 1'b1;
               state_d   = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_mc_q    <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         req_addr_q  <= '0;
         req_mc_q    <= '0;
         req_hit_q   <= 1'b0;
         req_way_q   <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               tag_q[s][w]  <= '0;
               data_q[s][w] <= '0;
            end
         end
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_mc_q    <= mem_mc_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         req_addr_q  <= req_addr_d;
         req_mc_q    <= req_mc_d;
         req_hit_q   <= req_hit_d;
         req_way_q   <= req_way_d;
         valid_q     <= valid_d;
         tag_q       <= tag_d;
         data_q      <= data_d;
      end
   end

   assign cpu_busy       = (state_q != ST_IDLE);
   assign cpu_ready      = ready_q;
   assign cpu_rdata      = rdata_q;
   assign mem_req        = mem_req_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign mem_memcontrol = mem_mc_q;
   assign hit_count      = hit_cnt_q;
   assign miss_count     = miss_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_nway_ctrl.sv
// ============================================================================
// Module   : tb_cache_nway_ctrl
// Brief    : Directed self-checking bench for cache_nway_ctrl (2-way, 8 sets).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cache_nway_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, cpu_flush;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [2:0]  memcontrol;
   logic        cpu_busy, cpu_ready;
   logic [31:0] cpu_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [2:0]  mem_memcontrol;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [3:0]  hit_count, miss_count;

   int          n_checks = 0;
   int          n_errors = 0;

   int          mem_delay = 2;
   logic [31:0] mem_data  = '0;
   int          mem_cnt;
   logic [31:0] log_addr, log_wdata;
   logic        log_we;
   logic [2:0]  log_mc;

   always #5 clk = ~clk;

   cache_nway_ctrl #(
      .ADDRESS_WIDTH (32),
      .DATA_WIDTH    (32),
      .WAYS          (2),
      .SETS          (8),
      .CNT_WIDTH     (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .memcontrol     (memcontrol),
      .cpu_flush      (cpu_flush),
      .cpu_busy       (cpu_busy),
      .cpu_ready      (cpu_ready),
      .cpu_rdata      (cpu_rdata),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_memcontrol (mem_memcontrol),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .hit_count      (hit_count),
      .miss_count     (miss_count)
   );

   // Memory model: acks after mem_delay extra cycles and logs the request.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      mem_cnt   = 0;
      log_addr  = '0;
      log_wdata = '0;
      log_we    = 1'b0;
      log_mc    = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_ack) begin
            mem_ack = 1'b0;
            mem_cnt = 0;
         end else if (mem_req && rst) begin
            if (mem_cnt >= mem_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_data;
               log_addr  = mem_addr;
               log_wdata = mem_wdata;
               log_we    = mem_we;
               log_mc    = mem_memcontrol;
               mem_cnt   = 0;
            end else begin
               mem_cnt++;
            end
         end else begin
            mem_cnt = 0;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] mc, output logic [31:0] data, output int lat);
      logic seen;
      cpu_we     = we;
      cpu_addr   = addr;
      cpu_wdata  = wdata;
      memcontrol = mc;
      cpu_req    = 1'b1;
      lat        = 0;
      data       = '0;
      seen       = 1'b0;
      while (!seen && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
         if (cpu_ready) begin
            seen = 1'b1;
            data = cpu_rdata;
         end
      end
      cpu_req = 1'b0;
      check_val("ready_seen", {31'd0, seen}, 32'd1);
   endtask

   task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] mc,
                          input logic [31:0] exp_data, input int exp_lat);
      logic [31:0] d;
      int          l;
      access(1'b0, addr, '0, mc, d, l);
      check_val({tag, "_data"}, d, exp_data);
      check_val({tag, "_lat"}, 32'(l), 32'(exp_lat));
   endtask

   task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] mc, input int exp_lat);
      logic [31:0] d;
      int          l;
      access(1'b1, addr, wdata, mc, d, l);
      check_val({tag, "_lat"}, 32'(l), 32'(exp_lat));
   endtask

   initial begin
      logic seen_ready;
      rst        = 1'b0;
      cpu_req    = 1'b0;
      cpu_we     = 1'b0;
      cpu_flush  = 1'b0;
      cpu_addr   = '0;
      cpu_wdata  = '0;
      memcontrol = 3'b010;

      repeat (2) @(posedge clk);
      #1;
      check_val("rst_busy",  {31'd0, cpu_busy},  32'd0);
      check_val("rst_ready", {31'd0, cpu_ready}, 32'd0);
      check_val("rst_mreq",  {31'd0, mem_req},   32'd0);
      check_val("rst_mwe",   {31'd0, mem_we},    32'd0);
      check_val("rst_rdata", cpu_rdata,          32'd0);
      check_val("rst_hits",  32'(hit_count),     32'd0);
      check_val("rst_miss",  32'(miss_count),    32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Cold miss then hit on the same word
      mem_delay = 2;
      mem_data  = 32'hDEAD_BEEF;
      do_load("lw_miss", 32'h40, 3'b010, 32'hDEAD_BEEF, 4);
      check_val("fill_addr", log_addr, 32'h40);
      check_val("fill_we", {31'd0, log_we}, 32'd0);
      check_val("miss_1", 32'(miss_count), 32'd1);
      do_load("lw_hit", 32'h40, 3'b010, 32'hDEAD_BEEF, 1);
      check_val("hit_1", 32'(hit_count), 32'd1);
      check_val("hit_nomreq", {31'd0, mem_req}, 32'd0);

      // Store hit full word, then sub-word loads
      do_store("sw_hit", 32'h40, 32'h80FF_1234, 3'b010, 4);
      check_val("sw_we", {31'd0, log_we}, 32'd1);
      check_val("sw_addr", log_addr, 32'h40);
      do_load("lb",  32'h43, 3'b000, 32'hFFFF_FF80, 1);
      do_load("lbu", 32'h43, 3'b100, 32'h0000_0080, 1);
      do_load("lh",  32'h42, 3'b001, 32'hFFFF_80FF, 1);
      do_load("lhu", 32'h42, 3'b101, 32'h0000_80FF, 1);

      do_store("sb", 32'h41, 32'h1234_56AA, 3'b000, 4);
      check_val("sb_we",   {31'd0, log_we}, 32'd1);
      check_val("sb_addr", log_addr, 32'h41);
      check_val("sb_mc",   32'(log_mc), 32'd0);
      check_val("sb_wdat", log_wdata, 32'h1234_56AA);
      do_load("lw_merged", 32'h40, 3'b010, 32'h80FF_AA34, 1);

      // Store miss: no allocation
      do_store("sw_miss", 32'h108, 32'h0000_0055, 3'b010, 4);
      mem_data = 32'h1111_2222;
      do_load("lw_after_swmiss", 32'h108, 3'b010, 32'h1111_2222, 4);
      check_val("hit_8",  32'(hit_count),  32'd8);
      check_val("miss_3", 32'(miss_count), 32'd3);

      // LRU in set 1: A, B, A, C -> C evicts B
      mem_data = 32'hA0A0_A0A0;
      do_load("lru_a", 32'h04, 3'b010, 32'hA0A0_A0A0, 4);
      mem_data = 32'hB0B0_B0B0;
      do_load("lru_b", 32'h24, 3'b010, 32'hB0B0_B0B0, 4);
      do_load("lru_a_hit", 32'h04, 3'b010, 32'hA0A0_A0A0, 1);
      mem_data = 32'hC0C0_C0C0;
      do_load("lru_c", 32'h44, 3'b010, 32'hC0C0_C0C0, 4);
      do_load("lru_a_hit2", 32'h04, 3'b010, 32'hA0A0_A0A0, 1);
      mem_data = 32'h1234_5678;
      do_load("lru_b_miss", 32'h26, 3'b101, 32'h0000_1234, 4);
      check_val("fill_align", log_addr, 32'h24);
      check_val("hit_10", 32'(hit_count),  32'd10);
      check_val("miss_7", 32'(miss_count), 32'd7);

      // Flush wins over a simultaneous request
      cpu_flush  = 1'b1;
      cpu_req    = 1'b1;
      cpu_we     = 1'b0;
      cpu_addr   = 32'h04;
      memcontrol = 3'b010;
      @(posedge clk);
      #1;
      seen_ready = cpu_ready;
      cpu_flush  = 1'b0;
      cpu_req    = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         seen_ready = seen_ready | cpu_ready;
      end
      check_val("flush_ready", {31'd0, seen_ready}, 32'd0);
      check_val("flush_hits", 32'(hit_count),  32'd10);
      check_val("flush_miss", 32'(miss_count), 32'd7);
      mem_data = 32'h0BAD_F00D;
      do_load("lw_after_flush", 32'h40, 3'b010, 32'h0BAD_F00D, 4);
      check_val("miss_8", 32'(miss_count), 32'd8);

      // Reset in the middle of a refill
      mem_delay  = 20;
      cpu_we     = 1'b0;
      cpu_addr   = 32'h04;
      memcontrol = 3'b010;
      cpu_req    = 1'b1;
      @(posedge clk);
      #1;
      check_val("fill_busy", {31'd0, cpu_busy}, 32'd1);
      check_val("fill_mreq", {31'd0, mem_req},  32'd1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_val("arst_mreq", {31'd0, mem_req},  32'd0);
      check_val("arst_busy", {31'd0, cpu_busy}, 32'd0);
      check_val("arst_hits", 32'(hit_count),    32'd0);
      check_val("arst_miss", 32'(miss_count),   32'd0);
      cpu_req = 1'b0;
      @(posedge clk);
      #1;
      rst       = 1'b1;
      mem_delay = 1;
      mem_data  = 32'hCAFE_F00D;
      do_load("lw_after_rst", 32'h04, 3'b010, 32'hCAFE_F00D, 3);
      check_val("post_rst_miss", 32'(miss_count), 32'd1);
      check_val("post_rst_hits", 32'(hit_count),  32'd0);

      // Hit counter saturation (4-bit counter, 16 hits)
      for (int i = 0; i < 16; i++)
         do_load("sat_hit", 32'h04, 3'b010, 32'hCAFE_F00D, 1);
      check_val("sat_hits", 32'(hit_count),  32'd15);
      check_val("sat_miss", 32'(miss_count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
